// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one start bit, NUM_DATA_BITS data bits
// (LSB first) and one stop bit onto a registered serial line.
//
// state | meaning
// IDLE  | line held at 1, waiting for an accepted tx_start
// START | start bit (0) on the line for one bit period
// DATA  | data bits shifted out LSB first, one per bit period
// STOP  | stop bit (1) on the line for one bit period, then tx_done
module uart_tx_framer #(
  parameter int NUM_DATA_BITS = 8,
  parameter int CLKS_PER_BIT  = 10
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     tx_start,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         bit_cnt, cnt_nxt;
  logic [IDX_W-1:0]         bit_idx, idx_nxt;
  logic [NUM_DATA_BITS-1:0] shreg, shreg_nxt;
  logic                     out_nxt;
  logic                     busy_nxt;
  logic                     done_nxt;
  logic                     bit_end;

  // Next-state and next-output decode; every register is computed here so
  // tx_out, tx_busy and tx_done all come straight from flops.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    out_nxt   = tx_out;
    done_nxt  = 1'b0;
    bit_end   = (bit_cnt == CNT_LAST);

    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      shreg_nxt = '0;
      out_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          out_nxt = 1'b1;
          if (tx_start) begin
            state_nxt = START;
            cnt_nxt   = CNT_ONE;
            idx_nxt   = '0;
            shreg_nxt = tx_data;
            out_nxt   = 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_nxt = DATA;
            cnt_nxt   = CNT_ONE;
            out_nxt   = shreg[0];
            shreg_nxt = shreg >> 1;
          end else begin
            cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_nxt = CNT_ONE;
            if (bit_idx == IDX_LAST) begin
              state_nxt = STOP;
              idx_nxt   = '0;
              out_nxt   = 1'b1;
            end else begin
              idx_nxt   = bit_idx + IDX_ONE;
              out_nxt   = shreg[0];
              shreg_nxt = shreg >> 1;
            end
          end else begin
            cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            shreg_nxt = '0;
            out_nxt   = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          shreg_nxt = '0;
          out_nxt   = 1'b1;
        end
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= shreg_nxt;
      tx_out  <= out_nxt;
      tx_busy <= busy_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: stimulus pushes hand-computed line
// patterns, per-lane monitors capture the line while busy and compare on tx_done.
module tb_uart_tx_framer;

  typedef struct {
    logic [15:0] bits;   // bits[i] = i-th bit on the line (start first)
    int          nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;

  // lane a: 8 data bits, 10 clocks per bit
  logic       clear_a = 1'b0;
  logic       start_a = 1'b0;
  logic [7:0] data_a  = 8'h00;
  logic       out_a, busy_a, done_a;

  // lane b: 5 data bits, 2 clocks per bit
  logic       clear_b = 1'b0;
  logic       start_b = 1'b0;
  logic [4:0] data_b  = 5'h00;
  logic       out_b, busy_b, done_b;

  frame_t exp_a[$];
  frame_t exp_b[$];

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_framer #(.NUM_DATA_BITS(8), .CLKS_PER_BIT(10)) dut_a (
    .clk(clk), .n_rst(n_rst), .clear(clear_a), .tx_start(start_a),
    .tx_data(data_a), .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx_framer #(.NUM_DATA_BITS(5), .CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .clear(clear_b), .tx_start(start_b),
    .tx_data(data_b), .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lane, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(lane != 0 ? done_b : done_a) && n < budget);
    if (!(lane != 0 ? done_b : done_a)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_done lane %0d: no tx_done within %0d cycles", lane, budget);
    end
  endtask

  task automatic push_frame(input int lane, input logic [15:0] bits, input int nbits);
    frame_t f;
    f.bits  = bits;
    f.nbits = nbits;
    if (lane != 0) exp_b.push_back(f);
    else           exp_a.push_back(f);
  endtask

  // Captures the line every cycle while busy; on tx_done pops and compares.
  task automatic monitor(input int lane);
    bit     line_q[$];
    bit     prev_busy;
    bit     prev_done;
    bit     o, bs, dn;
    int     cpb;
    int     bad;
    frame_t e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    cpb = (lane != 0) ? 2 : 10;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        line_q.delete();
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        o  = (lane != 0) ? out_b  : out_a;
        bs = (lane != 0) ? busy_b : busy_a;
        dn = (lane != 0) ? done_b : done_a;
        if (bs) line_q.push_back(o);
        if (dn) begin
          check($sformatf("done_width lane %0d", lane), 32'(prev_done), 32'd0);
          if ((lane != 0 ? exp_b.size() : exp_a.size()) == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done lane %0d: got tx_done expected none", lane);
          end else begin
            if (lane != 0) e = exp_b.pop_front();
            else           e = exp_a.pop_front();
            check($sformatf("frame_len lane %0d", lane), line_q.size(), e.nbits * cpb);
            bad = 0;
            for (int k = 0; k < line_q.size(); k++)
              if (k / cpb < e.nbits && line_q[k] != e.bits[k / cpb]) bad++;
            check($sformatf("frame_bits lane %0d (bad cycles)", lane), bad, 32'd0);
            check($sformatf("done_idle_line lane %0d", lane), 32'(o), 32'd1);
          end
          line_q.delete();
        end else if (prev_busy && !bs) begin
          line_q.delete();
        end
        prev_busy = bs;
        prev_done = dn;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $finish;
  end

  initial begin
    int n;
    int cnt_busy;
    int cnt_done;

    // Reset state
    n_rst = 1'b0;
    tick(); tick();
    check("rst_out",  32'(out_a),  32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    n_rst = 1'b1;
    tick();

    // Single frame 0xA5
    push_frame(0, 16'b1101001010, 10);
    data_a = 8'hA5; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("a5_start_bit", 32'(out_a), 32'd0);
    check("a5_busy", 32'(busy_a), 32'd1);
    wait_done(0, 150, n);
    check("a5_accept_to_done", n, 100);
    tick(); tick();

    // Back-to-back 0x00 then 0xFF, second request in the tx_done cycle
    push_frame(0, 16'b1000000000, 10);
    push_frame(0, 16'b1111111110, 10);
    data_a = 8'h00; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 150, n);
    data_a = 8'hFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("b2b_start_bit", 32'(out_a), 32'd0);
    wait_done(0, 150, n);
    check("b2b_accept_to_done", n, 100);
    tick(); tick();

    // Busy rejection: 0x3C request 35 cycles into a 0x81 frame
    push_frame(0, 16'b1100000010, 10);
    data_a = 8'h81; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (35) tick();
    data_a = 8'h3C; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 150, n);
    cnt_busy = 0;
    repeat (30) begin
      tick();
      if (busy_a) cnt_busy++;
    end
    check("reject_no_second_frame", cnt_busy, 0);

    // Clear at cycle 47 of a frame, with a competing tx_start
    data_a = 8'hC3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (46) tick();
    clear_a = 1'b1; start_a = 1'b1; data_a = 8'h77;
    tick();
    clear_a = 1'b0; start_a = 1'b0;
    check("clear_out",  32'(out_a),  32'd1);
    check("clear_busy", 32'(busy_a), 32'd0);
    check("clear_done", 32'(done_a), 32'd0);
    cnt_busy = 0;
    cnt_done = 0;
    repeat (20) begin
      tick();
      if (busy_a) cnt_busy++;
      if (done_a) cnt_done++;
    end
    check("clear_quiet_busy", cnt_busy, 0);
    check("clear_quiet_done", cnt_done, 0);
    push_frame(0, 16'b1010110100, 10);
    data_a = 8'h5A; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 150, n);
    check("5a_accept_to_done", n, 100);
    tick(); tick();

    // Asynchronous reset during DATA
    data_a = 8'h33; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (30) tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_out",  32'(out_a),  32'd1);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    tick(); tick();
    n_rst = 1'b1;
    push_frame(0, 16'b1000100100, 10);
    data_a = 8'h12; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 150, n);
    check("12_accept_to_done", n, 100);
    tick(); tick();

    // Narrow configuration: 5 data bits, 2 clocks per bit, 0x15
    push_frame(1, 16'b1101010, 7);
    data_b = 5'h15; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_start_bit", 32'(out_b), 32'd0);
    wait_done(1, 40, n);
    check("b_accept_to_done", n, 14);

    repeat (5) tick();
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
